// File: rtl/pq_pkg.sv
// Shared types for the priority-queue demonstrator: FSM states, queue entry and LFSR step.
package pq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADD,
    REMOVE,
    DISPLAY
  } state_t;

  typedef struct packed {
    logic [7:0] key;
    logic [7:0] payload;
  } entry_t;

  // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/pq_sorted_array.sv
// Sorted shift-register priority queue, smallest key at slot 0; push and pop each take one cycle.
// Pushes at full and pops at empty are dropped; clear wins over pop, pop wins over push.
module pq_sorted_array
  import pq_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   clear,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int CW = $clog2(DEPTH + 1);

  entry_t          mem [DEPTH];
  logic [CW-1:0]   count;
  logic [DEPTH-1:0] stay;

  // Occupied slots whose key is <= the new key keep their place, so equal keys stay in arrival order.
  always_comb begin
    stay = '0;
    for (int i = 0; i < DEPTH; i++) begin
      stay[i] = (CW'(i) < count) && (mem[i].key <= push_data.key);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      count <= '0;
    end else if (pop && !empty) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem[i] <= mem[i+1];
      end
      count <= count - CW'(1);
    end else if (push && !full) begin
      if (!stay[0]) begin
        mem[0] <= push_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (!stay[i]) begin
          mem[i] <= stay[i-1] ? push_data : mem[i-1];
        end
      end
      count <= count + CW'(1);
    end
  end

  assign head  = mem[0];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/high_level_pq.sv
// Self-running demo: fills the queue from an LFSR, then shows each item in priority order for DISPLAY_CYCLES.
// A run always completes once started; start is only looked at in IDLE.
module high_level_pq
  import pq_pkg::*;
#(
  parameter int          DEPTH          = 16,
  parameter int          DISPLAY_CYCLES = 640,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] data1,
  output logic [7:0] data2,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [2:0] blue,
  output logic       sigIDLE,
  output logic       sigSTART,
  output logic       sigADD,
  output logic       sigREMOVE,
  output logic       sigDISPLAY,
  output logic       sigFULL,
  output logic       sigEMPTY
);

  // One counter serves both the fill count in ADD and the hold time in DISPLAY.
  localparam int TMAX = (DISPLAY_CYCLES > DEPTH) ? DISPLAY_CYCLES : DEPTH;
  localparam int TW   = $clog2(TMAX);
  localparam logic [TW-1:0] ADD_LAST  = TW'(DEPTH - 1);
  localparam logic [TW-1:0] DISP_LAST = TW'(DISPLAY_CYCLES - 1);

  state_t         state;
  state_t         next_state;
  logic [15:0]    lfsr;
  logic [TW-1:0]  timer;
  logic           clear;
  logic           push;
  logic           pop;
  logic           full;
  logic           empty;
  entry_t         head;

  pq_sorted_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (push),
    .push_data (entry_t'(lfsr)),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    clear      = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          next_state = START;
        end
      end
      START: begin
        clear      = 1'b1;
        next_state = ADD;
      end
      ADD: begin
        push = 1'b1;
        if (timer == ADD_LAST) begin
          next_state = REMOVE;
        end
      end
      REMOVE: begin
        pop        = 1'b1;
        next_state = DISPLAY;
      end
      DISPLAY: begin
        if (timer == DISP_LAST) begin
          next_state = empty ? IDLE : REMOVE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer <= '0;
    end else if (next_state != state) begin
      timer <= '0;
    end else if (state == ADD || state == DISPLAY) begin
      timer <= timer + TW'(1);
    end
  end

  // Only reset reseeds, so back-to-back runs see fresh values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= LFSR_SEED;
    end else if (push) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data1 <= '0;
      data2 <= '0;
    end else if (pop) begin
      data1 <= head.key;
      data2 <= head.payload;
    end
  end

  assign sigIDLE    = (state == IDLE);
  assign sigSTART   = (state == START);
  assign sigADD     = (state == ADD);
  assign sigREMOVE  = (state == REMOVE);
  assign sigDISPLAY = (state == DISPLAY);
  assign sigFULL    = full;
  assign sigEMPTY   = empty;

  assign red   = sigDISPLAY ? data1[7:5] : 3'b000;
  assign green = sigDISPLAY ? data1[4:2] : 3'b000;
  assign blue  = sigDISPLAY ? data2[7:5] : 3'b000;

endmodule

// File: tb/tb_high_level_pq.sv
// Bench for high_level_pq plus a randomized unit run of pq_sorted_array against queue models.
module tb_high_level_pq;
  import pq_pkg::*;

  localparam int DEPTH          = 16;
  localparam int DISPLAY_CYCLES = 640;
  localparam int RUN_LEN        = 2 + DEPTH + DEPTH * (1 + DISPLAY_CYCLES);
  localparam int ADEPTH         = 4;

  localparam logic [6:0] F_IDLE    = 7'b1000000;
  localparam logic [6:0] F_START   = 7'b0100000;
  localparam logic [6:0] F_REMOVE  = 7'b0001000;
  localparam logic [6:0] F_FULL    = 7'b0000010;
  localparam logic [6:0] F_EMPTY   = 7'b0000001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data1, data2;
  logic [2:0] red, green, blue;
  logic       sigIDLE, sigSTART, sigADD, sigREMOVE, sigDISPLAY, sigFULL, sigEMPTY;

  logic   a_clear = 1'b0;
  logic   a_push  = 1'b0;
  logic   a_pop   = 1'b0;
  entry_t a_data  = '0;
  entry_t a_head;
  logic   a_full, a_empty;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [15:0] m_lfsr;
  logic [15:0] mq[$];
  logic [15:0] aq[$];

  always #5 clk = ~clk;

  high_level_pq #(
    .DEPTH(DEPTH), .DISPLAY_CYCLES(DISPLAY_CYCLES), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .data1(data1), .data2(data2), .red(red), .green(green), .blue(blue),
    .sigIDLE(sigIDLE), .sigSTART(sigSTART), .sigADD(sigADD), .sigREMOVE(sigREMOVE),
    .sigDISPLAY(sigDISPLAY), .sigFULL(sigFULL), .sigEMPTY(sigEMPTY)
  );

  pq_sorted_array #(.DEPTH(ADEPTH)) u_arr (
    .clk(clk), .rst(rst), .clear(a_clear), .push(a_push), .push_data(a_data),
    .pop(a_pop), .head(a_head), .full(a_full), .empty(a_empty)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [6:0] flags();
    return {sigIDLE, sigSTART, sigADD, sigREMOVE, sigDISPLAY, sigFULL, sigEMPTY};
  endfunction

  function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  // Index of the smallest key; strict < keeps the earliest-arrived among equals.
  function automatic int min_idx(input logic [15:0] q[$]);
    int best = 0;
    for (int i = 1; i < q.size(); i++) begin
      if (q[i][15:8] < q[best][15:8]) best = i;
    end
    return best;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic nudge(input bit en);
    if (en) start = 1'($urandom_range(0, 1));
  endtask

  task automatic async_reset();
    #2;
    rst   = 1'b0;
    start = 1'b0;
    #1;
    chk("rst_flags", 32'(flags()), 32'(F_IDLE | F_EMPTY));
    chk("rst_data", 32'({data1, data2}), 32'h0);
    chk("rst_rgb", 32'({red, green, blue}), 32'h0);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    rst    = 1'b1;
    m_lfsr = 16'hACE1;
  endtask

  // Entered at a negedge in IDLE with start high. abort_add>0 resets asynchronously that many cycles into ADD.
  task automatic run_pq(input int abort_add, input bit rand_start);
    int          n0, k, d, bad, bi;
    logic [15:0] it;
    logic [7:0]  prev;
    logic [8:0]  rgb0;
    n0 = cyc;
    mq.delete();
    for (int i = 0; i < DEPTH; i++) begin
      mq.push_back(m_lfsr);
      m_lfsr = ref_lfsr(m_lfsr);
    end
    step();
    chk("start_state", 32'(flags()), 32'(F_START | F_EMPTY));
    nudge(rand_start);
    step();
    chk("first_insert", 32'(dut.lfsr), 32'(mq[0]));
    if (abort_add > 0) chk("rerun_key_new", 32'(dut.lfsr[15:8] != 8'hAC), 32'h1);
    k = 0;
    while (sigADD && k < 100) begin
      if (abort_add > 0 && k == abort_add) begin
        async_reset();
        return;
      end
      k++;
      nudge(rand_start);
      step();
    end
    chk("add_len", 32'(k), 32'(DEPTH));
    chk("full_at_remove", 32'({sigREMOVE, sigFULL}), 32'h3);
    prev = 8'h00;
    for (int j = 0; j < DEPTH; j++) begin
      if (rand_start && j == DEPTH - 1) start = 1'b0;
      chk("remove_state", 32'(flags()), 32'(F_REMOVE | ((j == 0) ? F_FULL : 7'b0)));
      chk("rgb_remove", 32'({red, green, blue}), 32'h0);
      bi = min_idx(mq);
      it = mq[bi];
      mq.delete(bi);
      nudge(rand_start && j < DEPTH - 1);
      step();
      d    = 0;
      bad  = 0;
      rgb0 = {red, green, blue};
      while (sigDISPLAY && d < 1000) begin
        if ({red, green, blue} !== {it[15:13], it[12:10], it[7:5]}) bad++;
        if ({data1, data2} !== it) bad++;
        d++;
        nudge(rand_start && j < DEPTH - 1);
        step();
      end
      chk("pop_item", 32'({data1, data2}), 32'(it));
      chk("disp_len", 32'(d), 32'(DISPLAY_CYCLES));
      chk("disp_hold", 32'(bad), 32'h0);
      chk("order", 32'(data1 >= prev), 32'h1);
      if (it == 16'hACE1) chk("colour_ace1", 32'(rgb0), 32'(9'b101_011_111));
      prev = data1;
    end
    chk("idle_end", 32'(flags()), 32'(F_IDLE | F_EMPTY));
    chk("run_len", 32'(cyc - n0), 32'(RUN_LEN));
  endtask

  initial begin
    int          op;
    int          bi;
    logic [7:0]  seq;

    rst   = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_flags", 32'(flags()), 32'(F_IDLE | F_EMPTY));
    chk("reset_data", 32'({data1, data2}), 32'h0);
    chk("reset_rgb", 32'({red, green, blue}), 32'h0);
    rst = 1'b1;
    step();
    chk("idle_hold", 32'(flags()), 32'(F_IDLE | F_EMPTY));

    // Run 1 with start held: must land in IDLE and restart straight away as run 2.
    m_lfsr = 16'hACE1;
    start  = 1'b1;
    run_pq(0, 1'b0);
    run_pq(1 + $urandom_range(0, 12), 1'b0);

    repeat ($urandom_range(1, 20)) step();
    chk("idle_after_rst", 32'(flags()), 32'(F_IDLE | F_EMPTY));

    // Run 3: start toggles randomly mid-run and must be ignored.
    start = 1'b1;
    run_pq(0, 1'b1);
    step();
    chk("idle_stays", 32'(flags()), 32'(F_IDLE | F_EMPTY));

    // Sorted array: equal keys in arrival order, then random traffic against a queue model.
    a_clear = 1'b1;
    step();
    a_clear = 1'b0;
    a_push  = 1'b1;
    a_data  = entry_t'(16'h0501);
    step();
    a_data  = entry_t'(16'h0502);
    step();
    a_push  = 1'b0;
    chk("tie_head0", 32'(a_head), 32'h0501);
    a_pop = 1'b1;
    step();
    a_pop = 1'b0;
    chk("tie_head1", 32'(a_head), 32'h0502);
    a_pop = 1'b1;
    step();
    a_pop = 1'b0;
    chk("tie_empty", 32'(a_empty), 32'h1);

    aq.delete();
    seq = 8'h00;
    for (int c = 0; c < 400; c++) begin
      op     = $urandom_range(0, 2);
      a_push = 1'b0;
      a_pop  = 1'b0;
      if (op == 0 && aq.size() < ADEPTH) begin
        a_push = 1'b1;
        a_data = entry_t'({8'($urandom_range(0, 3)), seq});
        aq.push_back(a_data);
        seq++;
      end else if (op == 1 && aq.size() > 0) begin
        a_pop = 1'b1;
        bi = min_idx(aq);
        aq.delete(bi);
      end
      step();
      a_push = 1'b0;
      a_pop  = 1'b0;
      chk("arr_flags", 32'({a_full, a_empty}), 32'({aq.size() == ADEPTH, aq.size() == 0}));
      if (aq.size() > 0) begin
        bi = min_idx(aq);
        chk("arr_head", 32'(a_head), 32'(aq[bi]));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
